regfile_wr_arbiter: RTL and testbench

REGFILE_WR_ARBITER -- requirements
Module: regfile_wr_arbiter

---
 rtl/regfile_wr_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_regfile_wr_arbiter.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wr_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_wr_arbiter
//
// Purpose:
//   Shares the single write port of a register file among three requesters
//   (ALU writeback, memory load, I/O port) using round-robin arbitration.
//   It can also run a scrub sequence that writes zero to registers
//   1..2^AW-1, one register per cycle. Register 0 is hardwired to zero, so a
//   granted write that targets it completes the handshake but never asserts
//   load.
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous active-high reset
//   req[2:0]     write requests: bit0 ALU, bit1 memory load, bit2 I/O port
//   addr0..2     destination register for each requester (AW bits)
//   data0..2     write data for each requester (DW bits)
//   gnt[2:0]     one-hot (or zero) grant, combinational from req and state
//   scrub_start  request a zero-fill of registers 1..2^AW-1
//   busy         high while the scrub sequence runs (registered)
//   Caddr        register-file write address (registered)
//   C            register-file write data (registered)
//   load         register-file write enable (registered)
// -----------------------------------------------------------------------------
module regfile_wr_arbiter #(
  parameter int DW = 16,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [2:0]    req,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [AW-1:0] addr2,
  input  logic [DW-1:0] data0,
  input  logic [DW-1:0] data1,
  input  logic [DW-1:0] data2,
  output logic [2:0]    gnt,
  input  logic          scrub_start,
  output logic          busy,
  output logic [AW-1:0] Caddr,
  output logic [DW-1:0] C,
  output logic          load
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SCRUB = 1'b1;

  logic [0:0]    state_reg, state_next;
  logic [1:0]    rr_ptr_reg, rr_ptr_next;
  logic [AW-1:0] cnt_reg, cnt_next;
  logic [AW-1:0] caddr_reg, caddr_next;
  logic [DW-1:0] c_reg, c_next;
  logic          load_reg, load_next;

  // ---------------------------------------------------------------------------
  // Round-robin arbitration: rotate req so the pointer position lands at bit 0,
  // isolate the lowest set bit, then rotate the pick back to requester order.
  // ---------------------------------------------------------------------------
  logic [2:0] req_rot;
  logic [2:0] pick_rot;
  logic [2:0] gnt_raw;

  always_comb begin
    case (rr_ptr_reg)
      2'd1:    req_rot = {req[0], req[2], req[1]};
      2'd2:    req_rot = {req[1], req[0], req[2]};
      default: req_rot = req;
    endcase
  end

  assign pick_rot = req_rot & (~req_rot + 3'd1);

  always_comb begin
    case (rr_ptr_reg)
      2'd1:    gnt_raw = {pick_rot[1], pick_rot[0], pick_rot[2]};
      2'd2:    gnt_raw = {pick_rot[0], pick_rot[2], pick_rot[1]};
      default: gnt_raw = pick_rot;
    endcase
  end

  // Scrub start takes precedence over any request in the same cycle.
  assign gnt = (!reset && (state_reg == IDLE) && !scrub_start) ? gnt_raw : 3'b000;

  // ---------------------------------------------------------------------------
  // Grant-steered write mux (one-hot AND-OR).
  // ---------------------------------------------------------------------------
  logic [AW-1:0] addr_arr   [3];
  logic [DW-1:0] data_arr   [3];
  logic [AW-1:0] addr_masked[3];
  logic [DW-1:0] data_masked[3];
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_data;
  logic          grant_any;

  assign addr_arr[0] = addr0;
  assign addr_arr[1] = addr1;
  assign addr_arr[2] = addr2;
  assign data_arr[0] = data0;
  assign data_arr[1] = data1;
  assign data_arr[2] = data2;

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_mask
      assign addr_masked[gi] = gnt[gi] ? addr_arr[gi] : '0;
      assign data_masked[gi] = gnt[gi] ? data_arr[gi] : '0;
    end
  endgenerate

  assign sel_addr  = addr_masked[0] | addr_masked[1] | addr_masked[2];
  assign sel_data  = data_masked[0] | data_masked[1] | data_masked[2];
  assign grant_any = |gnt;

  // ---------------------------------------------------------------------------
  // Next-state logic.
  // The scrub counter walks 1..2^AW-1; its wrap to 0 marks the sequence done,
  // so busy stays high through every scrub write and drops one edge later.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next  = state_reg;
    rr_ptr_next = rr_ptr_reg;
    cnt_next    = cnt_reg;
    caddr_next  = caddr_reg;
    c_next      = c_reg;
    load_next   = 1'b0;

    case (state_reg)
      IDLE: begin
        if (scrub_start) begin
          state_next = SCRUB;
          cnt_next   = AW'(1);
        end else if (grant_any) begin
          caddr_next = sel_addr;
          c_next     = sel_data;
          load_next  = (sel_addr != '0);
          case (gnt)
            3'b001:  rr_ptr_next = 2'd1;
            3'b010:  rr_ptr_next = 2'd2;
            default: rr_ptr_next = 2'd0;
          endcase
        end
      end
      default: begin
        if (cnt_reg != '0) begin
          caddr_next = cnt_reg;
          c_next     = '0;
          load_next  = 1'b1;
          cnt_next   = cnt_reg + AW'(1);
        end else begin
          state_next = IDLE;
          cnt_next   = AW'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg  <= IDLE;
      rr_ptr_reg <= 2'd0;
      cnt_reg    <= AW'(1);
      caddr_reg  <= '0;
      c_reg      <= '0;
      load_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      rr_ptr_reg <= rr_ptr_next;
      cnt_reg    <= cnt_next;
      caddr_reg  <= caddr_next;
      c_reg      <= c_next;
      load_reg   <= load_next;
    end
  end

  assign busy  = (state_reg == SCRUB);
  assign Caddr = caddr_reg;
  assign C     = c_reg;
  assign load  = load_reg;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_regfile_wr_arbiter
//
// Purpose:
//   Self-checking bench for regfile_wr_arbiter (DW=16, AW=4). A behavioural
//   model tracks the expected outputs; a negedge process compares every cycle,
//   and the directed sequence adds literal expectations at known points.
// -----------------------------------------------------------------------------
module tb_regfile_wr_arbiter;
  localparam int DW   = 16;
  localparam int AW   = 4;
  localparam int NREG = 1 << AW;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [2:0]    req = 3'b000;
  logic [AW-1:0] addr0 = '0, addr1 = '0, addr2 = '0;
  logic [DW-1:0] data0 = '0, data1 = '0, data2 = '0;
  logic          scrub_start = 1'b0;
  logic [2:0]    gnt;
  logic          busy;
  logic [AW-1:0] Caddr;
  logic [DW-1:0] C;
  logic          load;

  int checks = 0;
  int errors = 0;

  regfile_wr_arbiter #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .reset(reset), .req(req),
    .addr0(addr0), .addr1(addr1), .addr2(addr2),
    .data0(data0), .data1(data1), .data2(data2),
    .gnt(gnt), .scrub_start(scrub_start), .busy(busy),
    .Caddr(Caddr), .C(C), .load(load)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model
  // ---------------------------------------------------------------------------
  int  m_ptr, m_next, m_caddr, m_c;
  bit  m_scrub, m_load, m_known;
  int  m_win;
  int  w_addr, w_data;
  logic [2:0] m_gnt;

  // First requester at or after the pointer, wrapping, that is asking.
  function automatic int winner(input logic [2:0] r, input int p);
    for (int k = 0; k < 3; k++) begin
      if (r[(p + k) % 3]) return (p + k) % 3;
    end
    return -1;
  endfunction

  always_comb begin
    m_win  = winner(req, m_ptr);
    w_addr = (m_win == 0) ? int'(addr0) : (m_win == 1) ? int'(addr1) : int'(addr2);
    w_data = (m_win == 0) ? int'(data0) : (m_win == 1) ? int'(data1) : int'(data2);
    m_gnt  = 3'b000;
    if (!reset && !m_scrub && !scrub_start && m_win >= 0) m_gnt = 3'(1 << m_win);
  end

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_ptr <= 0; m_scrub <= 0; m_next <= 1;
      m_caddr <= 0; m_c <= 0; m_load <= 0; m_known <= 1;
    end else if (m_scrub) begin
      if (m_next <= NREG - 1) begin
        m_caddr <= m_next; m_c <= 0; m_load <= 1; m_known <= 1;
        m_next  <= m_next + 1;
      end else begin
        m_scrub <= 0; m_load <= 0;
      end
    end else if (scrub_start) begin
      m_scrub <= 1; m_next <= 1; m_load <= 0;
    end else if (m_win >= 0) begin
      m_caddr <= w_addr; m_c <= w_data;
      m_load  <= (w_addr != 0);
      // Address/data of a register-0 write are not architecturally visible.
      m_known <= (w_addr != 0);
      m_ptr   <= (m_win + 1) % 3;
    end else begin
      m_load <= 0;
    end
  end

  always @(negedge clk) begin
    check("cyc_gnt",  32'(gnt),  32'(m_gnt));
    check("cyc_load", 32'(load), 32'(m_load));
    check("cyc_busy", 32'(busy), 32'(m_scrub));
    if (m_known) begin
      check("cyc_caddr", 32'(Caddr), 32'(m_caddr));
      check("cyc_c",     32'(C),     32'(m_c));
    end
  end

  // ---------------------------------------------------------------------------
  // Directed stimulus with literal expectations
  // ---------------------------------------------------------------------------
  task automatic step;
    @(posedge clk);
    #1;
  endtask

  logic [2:0] fair_exp [6];

  initial begin
    fair_exp = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};

    // Reset: outputs cleared, gnt suppressed even with all requests high
    step; step;
    req = 3'b111;
    #1;
    check("rst_gnt",   32'(gnt),   32'h0);
    check("rst_load",  32'(load),  32'h0);
    check("rst_busy",  32'(busy),  32'h0);
    check("rst_caddr", 32'(Caddr), 32'h0);
    check("rst_c",     32'(C),     32'h0);
    step;
    reset = 1'b0; req = 3'b000;
    step;

    // Single request
    req = 3'b001; addr0 = 4'd3; data0 = 16'hBEEF;
    #1 check("single_gnt", 32'(gnt), 32'h1);
    step;
    req = 3'b000;
    #1;
    check("single_caddr", 32'(Caddr), 32'h3);
    check("single_c",     32'(C),     32'hBEEF);
    check("single_load",  32'(load),  32'h1);
    step;
    check("single_load_off", 32'(load), 32'h0);

    // Register-0 write: handshake completes, no load (pointer now 1)
    req = 3'b010; addr1 = 4'd0; data1 = 16'h1234;
    #1 check("zero_gnt", 32'(gnt), 32'h2);
    step;
    req = 3'b000;
    #1 check("zero_load", 32'(load), 32'h0);

    // I/O port request brings the pointer back to 0
    req = 3'b100; addr2 = 4'd6; data2 = 16'h5555;
    #1 check("io_gnt", 32'(gnt), 32'h4);
    step;
    req = 3'b000;
    #1;
    check("io_caddr", 32'(Caddr), 32'h6);
    check("io_load",  32'(load),  32'h1);

    // Fairness: all three held for six cycles
    addr0 = 4'd1; data0 = 16'h1111;
    addr1 = 4'd2; data1 = 16'h2222;
    addr2 = 4'd5; data2 = 16'h3333;
    req = 3'b111;
    for (int i = 0; i < 6; i++) begin
      #1;
      check("fair_gnt", 32'(gnt), 32'(fair_exp[i]));
      if (i > 0) check("fair_load", 32'(load), 32'h1);
      step;
    end
    req = 3'b000;
    #1;
    check("fair_last_caddr", 32'(Caddr), 32'h5);
    check("fair_last_c",     32'(C),     32'h3333);
    check("fair_last_load",  32'(load),  32'h1);

    // Scrub beats a simultaneous request
    req = 3'b100; addr2 = 4'd9; data2 = 16'hAAAA; scrub_start = 1'b1;
    #1 check("scrub_gnt0", 32'(gnt), 32'h0);
    step;
    scrub_start = 1'b0;
    #1;
    check("scrub_busy_enter", 32'(busy), 32'h1);
    check("scrub_load_enter", 32'(load), 32'h0);
    for (int k = 1; k < NREG; k++) begin
      step;
      #1;
      check("scrub_load",  32'(load),  32'h1);
      check("scrub_caddr", 32'(Caddr), 32'(k));
      check("scrub_c",     32'(C),     32'h0);
      check("scrub_busy",  32'(busy),  32'h1);
      check("scrub_gnt",   32'(gnt),   32'h0);
    end
    step;
    #1;
    check("scrub_busy_fall", 32'(busy), 32'h0);
    check("scrub_load_fall", 32'(load), 32'h0);
    check("post_scrub_gnt",  32'(gnt),  32'h4);
    step;
    req = 3'b000;
    #1;
    check("post_scrub_caddr", 32'(Caddr), 32'h9);
    check("post_scrub_c",     32'(C),     32'hAAAA);
    check("post_scrub_load",  32'(load),  32'h1);

    // Move pointer to 1, then reset in the middle of a scrub
    req = 3'b001; addr0 = 4'd4; data0 = 16'h7777;
    #1 check("pre_abort_gnt", 32'(gnt), 32'h1);
    step;
    req = 3'b000; scrub_start = 1'b1;
    step;
    scrub_start = 1'b0;
    repeat (7) step;
    #1;
    check("abort_caddr7", 32'(Caddr), 32'h7);
    check("abort_load7",  32'(load),  32'h1);
    reset = 1'b1;
    #1;
    check("abort_load",  32'(load),  32'h0);
    check("abort_busy",  32'(busy),  32'h0);
    check("abort_gnt",   32'(gnt),   32'h0);
    check("abort_caddr", 32'(Caddr), 32'h0);
    step;
    reset = 1'b0;
    // Pointer reset to 0: requester 0 wins over requester 2
    req = 3'b101;
    #1 check("after_abort_gnt", 32'(gnt), 32'h1);
    check("after_abort_busy", 32'(busy), 32'h0);
    step;
    req = 3'b000;
    #1;
    check("after_abort_caddr", 32'(Caddr), 32'h4);
    check("after_abort_c",     32'(C),     32'h7777);
    check("after_abort_load",  32'(load),  32'h1);
    step; step;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
